// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_adder_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ripplecarry_adder.sv
// 4-bit ripple-carry adder used as the shared nibble datapath.
module ripplecarry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[4];
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial add/subtract with valid/ready handshakes on both sides.
// One shared 4-bit adder processes operands LSB nibble first.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB  = WIDTH / NIB_W;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    state_e            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic [NIB_W-1:0]  nib_a;
    logic [NIB_W-1:0]  nib_b;
    logic [NIB_W-1:0]  nib_s;
    logic              nib_c;

    always_comb begin
        nib_a = a_q[idx * NIB_W +: NIB_W];
        nib_b = b_q[idx * NIB_W +: NIB_W];
    end

    ripplecarry_adder u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_c)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract as A + ~B + 1: invert B here, seed carry with 1.
                        a_q   <= a;
                        b_q   <= op_sub ? ~b : b;
                        carry <= op_sub;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[idx * NIB_W +: NIB_W] <= nib_s;
                    carry <= nib_c;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        cout  <= nib_c;
                        ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (nib_s[NIB_W-1] != a_q[WIDTH-1]);
                        state <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl against a signed/unsigned arithmetic model.
module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from integer arithmetic on the operands.
    function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y, input logic s);
        int          sx;
        int          sy;
        int          r;
        int unsigned ux;
        int unsigned uy;
        logic        c;
        logic        v;
        logic [WIDTH-1:0] res;
        sx = $signed(x);
        sy = $signed(y);
        ux = {16'd0, x};
        uy = {16'd0, y};
        r  = s ? sx - sy : sx + sy;
        v  = (r > 32767) || (r < -32768);
        c  = s ? (ux >= uy) : ((ux + uy) >= 32'd65536);
        res = WIDTH'(r);
        return {v, c, res};
    endfunction

    task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic s, input int bp);
        logic [WIDTH+1:0] exp;
        int lat;
        exp = ref_op(x, y, s);
        check("idle_ready", {31'd0, in_ready}, 32'd1);
        a = x; b = y; op_sub = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            op_sub = 1'($urandom); in_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(NIB));
        check("sum", {16'd0, sum}, {16'd0, exp[WIDTH-1:0]});
        check("cout", {31'd0, cout}, {31'd0, exp[WIDTH]});
        check("ovf", {31'd0, ovf}, {31'd0, exp[WIDTH+1]});
        check("done_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < bp; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); in_valid = ~in_valid;
            @(posedge clk); #1;
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold", {14'd0, ovf, cout, sum}, {14'd0, exp});
        end
        out_ready = 1'b1;
        in_valid  = 1'($urandom);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_valid", {31'd0, out_valid}, 32'd0);
        check("release_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [WIDTH+1:0] q[$];
        logic [WIDTH+1:0] e;
        int last;
        int results;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
        a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_flags", {30'd0, cout, ovf}, 32'd0);

        do_op(16'h1234, 16'h0FFF, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(16'h0005, 16'h0007, 1'b1, 0);
        do_op(16'h8000, 16'h0001, 1'b1, 3);

        // Reset in the middle of RUN (idx=2), then a fresh request.
        a = 16'hABCD; b = 16'h1357; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        do_op(16'h0001, 16'h0001, 1'b0, 0);

        for (int k = 0; k < 30; k++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Back-to-back stream with both handshakes held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        last      = -1;
        results   = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); op_sub = 1'($urandom);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("b2b_spurious", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("b2b_result", {14'd0, ovf, cout, sum}, {14'd0, e});
                end
                if (last >= 0) check("b2b_spacing", 32'(cyc - last), 32'(NIB + 2));
                last = cyc;
                results++;
            end
            if (in_ready) q.push_back(ref_op(a, b, op_sub));
            @(posedge clk); #1;
        end
        check("b2b_count", 32'(results), 32'd10);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
